score_arbiter: RTL and testbench

SCORE_ARBITER -- requirements
Module: score_arbiter

---
 rtl/score_arbiter.sv | 125 ++++++++++++
 tb/tb_score_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/score_arbiter.sv
// score_arbiter: round-robin arbiter that funnels per-requester score updates
// into a single counter increase/decrease pair, one registered grant per cycle.
// Optional feature: define SCORE_ARB_STATS_EN to add the 16-bit grant_cnt and
// sub_cnt statistics outputs; without it they are absent from the port list.
module score_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int AMT_W   = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*AMT_W-1:0] amount,
  input  logic [NUM_REQ-1:0]       sub,
  input  logic                     freeze,
  output logic [NUM_REQ-1:0]       ack,
  output logic [AMT_W-1:0]         increase,
  output logic [AMT_W-1:0]         decrease,
  output logic                     busy
`ifdef SCORE_ARB_STATS_EN
  ,
  output logic [15:0]              grant_cnt,
  output logic [15:0]              sub_cnt
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, FROZEN} state_t;

  state_t               state_p1;
  state_t               state_nx;
  logic [PTR_W-1:0]     ptr_p1;
  logic [NUM_REQ-1:0]   elig_p0;
  logic                 grant_p0;
  logic [PTR_W-1:0]     gidx_p0;
  logic [AMT_W-1:0]     amt_p0;
  logic [NUM_REQ-1:0]   ack_nx;
  logic [AMT_W-1:0]     inc_nx;
  logic [AMT_W-1:0]     dec_nx;
  logic [PTR_W-1:0]     ptr_nx;
  int                   idx;

  assign busy = |req;

  // Round-robin search from ptr over the eligible set; a requester being acked
  // this cycle is masked so a held req is not granted twice.
  always_comb begin
    elig_p0  = req & ~ack;
    grant_p0 = 1'b0;
    gidx_p0  = '0;
    idx      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr_p1) + i) % NUM_REQ;
      if (!grant_p0 && elig_p0[idx]) begin
        grant_p0 = 1'b1;
        gidx_p0  = PTR_W'(idx);
      end
    end
    if (freeze || (state_p1 == FROZEN)) begin
      grant_p0 = 1'b0;
    end
  end

  // Next-state logic: a grant always wins, otherwise freeze parks the FSM.
  always_comb begin
    state_nx = state_p1;
    case (state_p1)
      IDLE, ISSUE: begin
        if (grant_p0)    state_nx = ISSUE;
        else if (freeze) state_nx = FROZEN;
        else             state_nx = IDLE;
      end
      FROZEN: begin
        state_nx = freeze ? FROZEN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output decode: amount and direction of the winner are captured at the grant.
  always_comb begin
    amt_p0 = amount[int'(gidx_p0)*AMT_W +: AMT_W];
    ack_nx = '0;
    inc_nx = '0;
    dec_nx = '0;
    ptr_nx = ptr_p1;
    if (grant_p0) begin
      ack_nx = NUM_REQ'(1) << gidx_p0;
      ptr_nx = PTR_W'((int'(gidx_p0) + 1) % NUM_REQ);
      if (sub[gidx_p0]) dec_nx = amt_p0;
      else              inc_nx = amt_p0;
    end
  end

  // ---- stage p1: registered state, pointer and counter-update outputs ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1 <= IDLE;
      ptr_p1   <= '0;
      ack      <= '0;
      increase <= '0;
      decrease <= '0;
    end else begin
      state_p1 <= state_nx;
      ptr_p1   <= ptr_nx;
      ack      <= ack_nx;
      increase <= inc_nx;
      decrease <= dec_nx;
    end
  end

`ifdef SCORE_ARB_STATS_EN
  // Statistics: every grant opens exactly one ISSUE cycle; counters wrap freely.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt <= '0;
      sub_cnt   <= '0;
    end else if (grant_p0) begin
      grant_cnt <= grant_cnt + 16'd1;
      if (sub[gidx_p0]) sub_cnt <= sub_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_score_arbiter.sv
// Scoreboard bench for score_arbiter: directed vectors push expected grants,
// a negedge monitor pops and compares whenever ack is presented.
module tb_score_arbiter;
  localparam int N = 4;
  localparam int W = 20;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [N*W-1:0]   amount;
  logic [N-1:0]     sub;
  logic             freeze;
  logic [N-1:0]     ack;
  logic [W-1:0]     increase;
  logic [W-1:0]     decrease;
  logic             busy;
`ifdef SCORE_ARB_STATS_EN
  logic [15:0]      grant_cnt;
  logic [15:0]      sub_cnt;
`endif

  always #5 clk = ~clk;

  score_arbiter #(.NUM_REQ(N), .AMT_W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .amount   (amount),
    .sub      (sub),
    .freeze   (freeze),
    .ack      (ack),
    .increase (increase),
    .decrease (decrease),
    .busy     (busy)
`ifdef SCORE_ARB_STATS_EN
    ,
    .grant_cnt(grant_cnt),
    .sub_cnt  (sub_cnt)
`endif
  );

  typedef struct packed {
    logic [N-1:0] a;
    logic [W-1:0] i;
    logic [W-1:0] d;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [N-1:0] a, input logic [W-1:0] i, input logic [W-1:0] d);
    exp_t e;
    e.a = a; e.i = i; e.d = d;
    q.push_back(e);
  endtask

  // one cycle; requesters drop their req once they see their ack
  task automatic step();
    @(posedge clk); #1;
    req = req & ~ack;
  endtask

  // one cycle; requesters keep req held regardless of ack
  task automatic step_hold();
    @(posedge clk); #1;
  endtask

  // Monitor: pop an expectation per ack; otherwise both update buses must be 0.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ack !== '0) begin
        if (q.size() == 0) begin
          check("unexpected_ack", 64'(ack), 64'(0));
        end else begin
          mon_e = q.pop_front();
          check("sb_ack", 64'(ack), 64'(mon_e.a));
          check("sb_increase", 64'(increase), 64'(mon_e.i));
          check("sb_decrease", 64'(decrease), 64'(mon_e.d));
        end
      end else begin
        check("idle_increase", 64'(increase), 64'(0));
        check("idle_decrease", 64'(decrease), 64'(0));
      end
    end
  end

  initial begin
    reset = 1'b1; req = '0; sub = '0; amount = '0; freeze = 1'b0;
    step_hold(); step_hold();
    reset = 1'b0;
    mon_en = 1'b1;
    check("rst_ack", 64'(ack), 64'(0));
    check("rst_increase", 64'(increase), 64'(0));
    check("rst_decrease", 64'(decrease), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));

    // single add request, one-cycle latency, then back to idle
    req = 4'b0001; amount[0*W +: W] = 20'd50;
    push(4'b0001, 20'd50, 20'd0);
    #1 check("t1_busy", 64'(busy), 64'(1));
    step();
    check("t1_ack", 64'(ack), 64'(4'b0001));
    check("t1_increase", 64'(increase), 64'(50));
    step();
    check("t1_idle_ack", 64'(ack), 64'(0));

    // realign ptr to 0, then four held requests served round-robin back to back
    reset = 1'b1; step_hold(); reset = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < N; k++) begin
      amount[k*W +: W] = W'(k + 1);
      push(N'(1) << k, W'(k + 1), '0);
    end
    for (int k = 0; k < N; k++) begin
      step();
      check("t2_ack", 64'(ack), 64'(N'(1) << k));
      check("t2_increase", 64'(increase), 64'(k + 1));
    end
    step();
    check("t2_idle_ack", 64'(ack), 64'(0));

    // subtract request raised while frozen waits for freeze to fall
    freeze = 1'b1; req = 4'b0100; sub = 4'b0100; amount[2*W +: W] = 20'd30;
    push(4'b0100, 20'd0, 20'd30);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t3_frozen_ack", 64'(ack), 64'(0));
      check("t3_frozen_busy", 64'(busy), 64'(1));
    end
    freeze = 1'b0;
    step();
    check("t3_unfreeze_ack", 64'(ack), 64'(0));
    step();
    check("t3_ack", 64'(ack), 64'(4'b0100));
    check("t3_decrease", 64'(decrease), 64'(30));
    check("t3_increase", 64'(increase), 64'(0));
    step();
    sub = '0;

    // reset during the ISSUE cycle of req1; held req1 is granted again afterwards
    req = 4'b0010; amount[1*W +: W] = 20'd77;
    push(4'b0010, 20'd77, 20'd0);
    step_hold();
    check("t4_issue_ack", 64'(ack), 64'(4'b0010));
    reset = 1'b1;
    step_hold();
    check("t4_rst_ack", 64'(ack), 64'(0));
    check("t4_rst_increase", 64'(increase), 64'(0));
    check("t4_rst_decrease", 64'(decrease), 64'(0));
    reset = 1'b0;
    push(4'b0010, 20'd77, 20'd0);
    step();
    check("t4_regrant_ack", 64'(ack), 64'(4'b0010));
    check("t4_regrant_increase", 64'(increase), 64'(77));
    step();
    check("t4_idle_ack", 64'(ack), 64'(0));

    // zero-amount grants still ack, for both directions
    req = 4'b1000; amount[3*W +: W] = 20'd0;
    push(4'b1000, 20'd0, 20'd0);
    step();
    check("t5_add0_ack", 64'(ack), 64'(4'b1000));
    step();
    req = 4'b0001; sub = 4'b0001; amount[0*W +: W] = 20'd0;
    push(4'b0001, 20'd0, 20'd0);
    step();
    check("t5_sub0_ack", 64'(ack), 64'(4'b0001));
    check("t5_sub0_decrease", 64'(decrease), 64'(0));
    step();
    sub = '0;

    // request withdrawn while frozen is never granted
    freeze = 1'b1; req = 4'b0001; amount[0*W +: W] = 20'd9;
    step(); step();
    req = '0; freeze = 1'b0;
    #1 check("t6_busy", 64'(busy), 64'(0));
    for (int k = 0; k < 4; k++) begin
      step();
      check("t6_no_ack", 64'(ack), 64'(0));
    end
    check("queue_empty", 64'(q.size()), 64'(0));

`ifdef SCORE_ARB_STATS_EN
    // 0x10000 consecutive grants alternating req0 (sub) and req1 (add)
    mon_en = 1'b0;
    reset = 1'b1; step_hold(); reset = 1'b0;
    check("st_rst_grant_cnt", 64'(grant_cnt), 64'(0));
    check("st_rst_sub_cnt", 64'(sub_cnt), 64'(0));
    req = 4'b0011; sub = 4'b0001;
    amount[0*W +: W] = 20'd1; amount[1*W +: W] = 20'd2;
    repeat (65535) step_hold();
    check("st_grant_cnt_ffff", 64'(grant_cnt), 64'(16'hFFFF));
    step_hold();
    req = '0; sub = '0;
    step_hold(); step_hold();
    check("st_grant_cnt_wrap", 64'(grant_cnt), 64'(0));
    check("st_sub_cnt", 64'(sub_cnt), 64'(16'h8000));
`endif

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
